// File: rtl/cdc_fifo_read_scheduler.sv
// Read-side pacer for the slow-to-fast audio CDC FIFO: primes to a fill level, then pops one sample per tick.
// Optional CDC_SCHED_UNDERRUN_MUTE_EN: output zero instead of repeating the last sample on underrun.
module cdc_fifo_read_scheduler #(
    parameter int PKT_WIDTH      = 16,
    parameter int TICK_DIV       = 136,
    parameter int PRIME_TICKS    = 2,
    parameter int UNDERRUN_LIMIT = 4,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 fifoEmpty_i,
    input  logic [PKT_WIDTH-1:0] fifoPkt_i,
    output logic                 rdEN_o,
    output logic [PKT_WIDTH-1:0] sample_o,
    output logic                 sampleValid_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] underrunCnt_o
);

    // state | meaning
    // IDLE  | disabled, counters parked, no pops
    // PRIME | letting the FIFO fill until PRIME_TICKS non-empty ticks in a row
    // RUN   | one pop and one sample strobe per tick
    // DRAIN | popping on alternate cycles until the FIFO reports empty
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRIME = 2'b01,
        RUN   = 2'b10,
        DRAIN = 2'b11
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(PRIME_TICKS + 1);
    localparam int UW = $clog2(UNDERRUN_LIMIT + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_TICKS);
    localparam logic [UW-1:0] UNDER_MAX  = UW'(UNDERRUN_LIMIT);

    state_t                state, nextState;
    logic [TW-1:0]         tickCnt, tickNext;
    logic                  tick_c;
    logic [PW-1:0]         primeCnt, primeNext, primeInc;
    logic [UW-1:0]         consecCnt, consecNext, consecInc;
    logic                  rdENNext, validNext;
    logic [PKT_WIDTH-1:0]  sampleNext;
    logic [CNT_WIDTH-1:0]  underrunNext;

    assign tick_c  = (state == PRIME || state == RUN) && (tickCnt == TICK_LAST);
    assign state_o = state;

    always_comb begin
        tickNext = tickCnt + TW'(1);
        if (state == IDLE || state == DRAIN || tick_c) begin
            tickNext = '0;
        end
    end

    always_comb begin
        nextState    = state;
        primeNext    = primeCnt;
        consecNext   = consecCnt;
        rdENNext     = 1'b0;
        validNext    = 1'b0;
        sampleNext   = sample_o;
        underrunNext = underrunCnt_o;
        primeInc     = primeCnt + PW'(1);
        consecInc    = consecCnt + UW'(1);
        case (state)
            IDLE: begin
                primeNext = '0;
                if (enable_i) nextState = PRIME;
            end
            PRIME: begin
                if (!enable_i) begin
                    nextState = DRAIN;
                end else if (tick_c) begin
                    if (fifoEmpty_i) begin
                        primeNext = '0;
                    end else begin
                        primeNext = primeInc;
                        if (primeInc == PRIME_DONE) begin
                            nextState  = RUN;
                            consecNext = '0;
                        end
                    end
                end
            end
            RUN: begin
                // disable wins over a coincident tick: no pop, no strobe
                if (!enable_i) begin
                    nextState = DRAIN;
                end else if (tick_c) begin
                    validNext = 1'b1;
                    if (!fifoEmpty_i) begin
                        rdENNext   = 1'b1;
                        sampleNext = fifoPkt_i;
                        consecNext = '0;
                    end else begin
`ifdef CDC_SCHED_UNDERRUN_MUTE_EN
                        sampleNext = '0;
`else
                        sampleNext = sample_o;
`endif
                        if (underrunCnt_o != '1) underrunNext = underrunCnt_o + CNT_WIDTH'(1);
                        consecNext = consecInc;
                        if (consecInc == UNDER_MAX) begin
                            nextState = PRIME;
                            primeNext = '0;
                        end
                    end
                end
            end
            DRAIN: begin
                // skip a cycle after each pop so the empty flag can catch up
                primeNext = '0;
                rdENNext  = !fifoEmpty_i && !rdEN_o;
                if (fifoEmpty_i && !rdEN_o) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            tickCnt       <= '0;
            primeCnt      <= '0;
            consecCnt     <= '0;
            rdEN_o        <= 1'b0;
            sampleValid_o <= 1'b0;
            sample_o      <= '0;
            underrunCnt_o <= '0;
        end else begin
            state         <= nextState;
            tickCnt       <= tickNext;
            primeCnt      <= primeNext;
            consecCnt     <= consecNext;
            rdEN_o        <= rdENNext;
            sampleValid_o <= validNext;
            sample_o      <= sampleNext;
            underrunCnt_o <= underrunNext;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_read_scheduler.sv
// Bench for cdc_fifo_read_scheduler: FWFT FIFO model plus a sample scoreboard.
module tb_cdc_fifo_read_scheduler;

    localparam int PKW = 16;
    localparam int TD  = 20;
    localparam int CW  = 8;
`ifdef CDC_SCHED_UNDERRUN_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           fifoEmpty = 1'b1;
    logic [PKW-1:0] fifoPkt = '0;
    logic           rdEN_o;
    logic [PKW-1:0] sample_o;
    logic           sampleValid_o;
    logic [1:0]     state_o;
    logic [CW-1:0]  underrunCnt_o;

    typedef struct packed {
        logic [PKW-1:0] smp;
        logic           rd;
        logic [CW-1:0]  ucnt;
    } exp_t;

    exp_t           expQ[$];
    exp_t           e;
    logic [PKW-1:0] fifoQ[$];
    int             nCompared = 0;
    int             nMismatch = 0;

    cdc_fifo_read_scheduler #(
        .PKT_WIDTH(PKW), .TICK_DIV(TD), .PRIME_TICKS(2), .UNDERRUN_LIMIT(4), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifoEmpty_i(fifoEmpty), .fifoPkt_i(fifoPkt),
        .rdEN_o(rdEN_o), .sample_o(sample_o), .sampleValid_o(sampleValid_o),
        .state_o(state_o), .underrunCnt_o(underrunCnt_o)
    );

    always #5 clk = ~clk;

    function automatic void updFifo();
        fifoEmpty = (fifoQ.size() == 0);
        fifoPkt   = fifoEmpty ? '0 : fifoQ[0];
    endfunction

    // FIFO pops on rdEN_o; scoreboard consumes one entry per strobe
    always @(negedge clk) begin
        if (rdEN_o && fifoQ.size() > 0) begin
            fifoQ.delete(0);
            updFifo();
        end
        if (sampleValid_o) begin
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatch++;
                $display("FAIL unexpected_valid: got sample=%h rd=%b, no sample expected", sample_o, rdEN_o);
            end else begin
                e = expQ.pop_front();
                if ({sample_o, rdEN_o, underrunCnt_o} !== {e.smp, e.rd, e.ucnt}) begin
                    nMismatch++;
                    $display("FAIL scoreboard: got sample=%h rd=%b ucnt=%0d, want sample=%h rd=%b ucnt=%0d",
                             sample_o, rdEN_o, underrunCnt_o, e.smp, e.rd, e.ucnt);
                end
            end
        end
    end

    task automatic doReset();
        rst = 1'b1;
        enable = 1'b0;
        fifoQ.delete();
        expQ.delete();
        updFifo();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nCompared++; if (state_o !== 2'b00) begin nMismatch++; $display("FAIL reset_state: got %b want 00", state_o); end
        nCompared++; if (rdEN_o !== 1'b0) begin nMismatch++; $display("FAIL reset_rdEN: got %b want 0", rdEN_o); end
        nCompared++; if (sample_o !== '0) begin nMismatch++; $display("FAIL reset_sample: got %h want 0000", sample_o); end
        nCompared++; if (sampleValid_o !== 1'b0) begin nMismatch++; $display("FAIL reset_valid: got %b want 0", sampleValid_o); end
        nCompared++; if (underrunCnt_o !== '0) begin nMismatch++; $display("FAIL reset_ucnt: got %0d want 0", underrunCnt_o); end
    endtask

    task automatic test_prime_run();
        int cyc;
        doReset();
        fifoQ = '{16'h1234, 16'h5678, 16'hABCD};
        updFifo();
        expQ.push_back('{16'h1234, 1'b1, 8'd0});
        expQ.push_back('{16'h5678, 1'b1, 8'd0});
        @(negedge clk);
        enable = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!sampleValid_o && cyc < 10 * TD);
        nCompared++; if (cyc != 3 * TD + 1) begin nMismatch++; $display("FAIL first_sample_latency: got %0d cycles want %0d", cyc, 3 * TD + 1); end
        nCompared++; if (state_o !== 2'b10) begin nMismatch++; $display("FAIL run_state: got %b want 10", state_o); end
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!sampleValid_o && cyc < 4 * TD);
        nCompared++; if (cyc != TD) begin nMismatch++; $display("FAIL tick_period: got %0d cycles want %0d", cyc, TD); end
        enable = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (state_o !== 2'b00 && cyc < 20);
        nCompared++; if (state_o !== 2'b00) begin nMismatch++; $display("FAIL drain_to_idle: got %b want 00", state_o); end
        nCompared++; if (fifoQ.size() != 0) begin nMismatch++; $display("FAIL drain_left_words: got %0d want 0", fifoQ.size()); end
        nCompared++; if (expQ.size() != 0) begin nMismatch++; $display("FAIL missing_samples: got %0d pending want 0", expQ.size()); end
    endtask

    task automatic test_underrun();
        int cyc;
        doReset();
        fifoQ.push_back(16'h0042);
        updFifo();
        expQ.push_back('{16'h0042, 1'b1, 8'd0});
        for (int i = 1; i <= 4; i++) expQ.push_back('{MUTE ? 16'h0000 : 16'h0042, 1'b0, 8'(i)});
        @(negedge clk);
        enable = 1'b1;
        cyc = 0;
        do begin @(negedge clk); #1; cyc++; end while (expQ.size() != 0 && cyc < 10 * TD);
        nCompared++; if (expQ.size() != 0) begin nMismatch++; $display("FAIL underrun_timeout: got %0d pending want 0", expQ.size()); end
        nCompared++; if (state_o !== 2'b01) begin nMismatch++; $display("FAIL underrun_reprime: got %b want 01", state_o); end
    endtask

    task automatic test_saturation();
        int cyc;
        int cur = 4;
        logic [PKW-1:0] w;
        for (int r = 0; r < 64; r++) begin
            w = PKW'(16'h0100 + r);
            fifoQ.push_back(w);
            updFifo();
            expQ.push_back('{w, 1'b1, 8'(cur)});
            for (int k = 0; k < 4; k++) begin
                cur = (cur >= 255) ? 255 : cur + 1;
                expQ.push_back('{MUTE ? 16'h0000 : w, 1'b0, 8'(cur)});
            end
            cyc = 0;
            do begin @(negedge clk); #1; cyc++; end while (expQ.size() != 0 && cyc < 10 * TD);
            if (expQ.size() != 0) begin
                nCompared++; nMismatch++;
                $display("FAIL saturation_round_timeout: got %0d pending want 0 (round %0d)", expQ.size(), r);
                break;
            end
        end
        nCompared++; if (underrunCnt_o !== 8'hFF) begin nMismatch++; $display("FAIL saturation: got %h want ff", underrunCnt_o); end
        nCompared++; if (state_o !== 2'b01) begin nMismatch++; $display("FAIL saturation_state: got %b want 01", state_o); end
        enable = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (state_o !== 2'b00 && cyc < 20);
    endtask

    task automatic test_disable_on_tick();
        int cyc;
        int pulses = 0;
        bit adjacent = 1'b0;
        logic prevRd = 1'b0;
        doReset();
        fifoQ = '{16'h0011, 16'h0022, 16'h0033};
        updFifo();
        @(negedge clk);
        enable = 1'b1;
        repeat (3 * TD) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        nCompared++; if (state_o !== 2'b11) begin nMismatch++; $display("FAIL disable_to_drain: got %b want 11", state_o); end
        nCompared++; if (sampleValid_o !== 1'b0) begin nMismatch++; $display("FAIL disable_tick_valid: got %b want 0", sampleValid_o); end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (rdEN_o) pulses++;
            if (rdEN_o && prevRd) adjacent = 1'b1;
            prevRd = rdEN_o;
        end while (state_o !== 2'b00 && cyc < 30);
        nCompared++; if (pulses != 3) begin nMismatch++; $display("FAIL drain_pulses: got %0d want 3", pulses); end
        nCompared++; if (adjacent) begin nMismatch++; $display("FAIL drain_alternate: got back-to-back pops want none"); end
        nCompared++; if (state_o !== 2'b00) begin nMismatch++; $display("FAIL drain_idle: got %b want 00", state_o); end
        nCompared++; if (fifoQ.size() != 0) begin nMismatch++; $display("FAIL drain_empty: got %0d words want 0", fifoQ.size()); end
    endtask

    task automatic test_prime_alternate();
        int cyc = 0;
        doReset();
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            while (cyc < (k - 1) * TD + TD / 2) begin @(negedge clk); cyc++; end
            if (k % 2 == 1) begin
                if (fifoQ.size() == 0) fifoQ.push_back(16'h5A5A);
            end else begin
                fifoQ.delete();
            end
            updFifo();
            while (cyc < 1 + k * TD) begin @(negedge clk); cyc++; end
            nCompared++;
            if (state_o !== 2'b01) begin nMismatch++; $display("FAIL prime_alternate: got %b want 01 after tick %0d", state_o, k); end
        end
        enable = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (state_o !== 2'b00 && cyc < 20);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        doReset();
        fifoQ = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        updFifo();
        expQ.push_back('{16'hAAAA, 1'b1, 8'd0});
        @(negedge clk);
        enable = 1'b1;
        cyc = 0;
        do begin @(negedge clk); #1; cyc++; end while (expQ.size() != 0 && cyc < 10 * TD);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({state_o, rdEN_o, sample_o, sampleValid_o, underrunCnt_o} !== '0) begin
            nMismatch++;
            $display("FAIL reset_mid_run: got state=%b rd=%b sample=%h valid=%b ucnt=%0d want all 0",
                     state_o, rdEN_o, sample_o, sampleValid_o, underrunCnt_o);
        end
        rst = 1'b0;
        expQ.push_back('{16'hBBBB, 1'b1, 8'd0});
        @(negedge clk);
        enable = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!sampleValid_o && cyc < 10 * TD);
        nCompared++; if (cyc != 3 * TD + 1) begin nMismatch++; $display("FAIL restart_latency: got %0d cycles want %0d", cyc, 3 * TD + 1); end
        enable = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (state_o !== 2'b00 && cyc < 20);
        nCompared++; if (fifoQ.size() != 0) begin nMismatch++; $display("FAIL restart_drain: got %0d words want 0", fifoQ.size()); end
    endtask

    initial begin
        test_reset();
        test_prime_run();
        test_underrun();
        test_saturation();
        test_disable_on_tick();
        test_prime_alternate();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/cdc_fifo_read_scheduler.md
Name: cdc_fifo_read_scheduler

Overview:
- Sits in the fast DSP clock domain (6 MHz) on the read side of the slow-to-fast audio CDC FIFO.
- Paces FIFO pops to a fixed sample tick (~44.1 kHz) and primes the FIFO to a target fill before streaming.
- Delivers one sample per tick to the DSP chain; on underrun it repeats the last sample and counts the event.
- On disable it drains the FIFO so a later restart begins clean.

Parameters:
- PKT_WIDTH, 16, audio sample width; matches the FIFO data width.
- TICK_DIV, 136, clk_i cycles per sample tick (6 MHz / 44.1 kHz); must be >= 4.
- PRIME_TICKS, 2, consecutive non-empty ticks required in PRIME before RUN; must be < FIFO depth (4).
- UNDERRUN_LIMIT, 4, consecutive underrun ticks in RUN that force a return to PRIME.
- CNT_WIDTH, 8, width of the underrun event counter.

Ports:
- clk_i  in  1  fast DSP clock; everything is in this domain.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  streaming enable; level-sensitive.
- fifoEmpty_i  in  1  FIFO empty flag (read domain).
- fifoPkt_i  in  PKT_WIDTH  FIFO first-word-fall-through read data.
- rdEN_o  out  1  FIFO read enable, registered.
- sample_o  out  PKT_WIDTH  sample to the DSP chain, registered.
- sampleValid_o  out  1  one-cycle strobe per tick while in RUN.
- state_o  out  2  current state: IDLE=00, PRIME=01, RUN=10, DRAIN=11.
- underrunCnt_o  out  CNT_WIDTH  saturating count of underrun ticks.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - state IDLE.
  - Tick counter, prime counter and consecutive-underrun counter are 0.
  - rdEN_o=0, sample_o=0, sampleValid_o=0, underrunCnt_o=0.
  - Reset mid-operation aborts any state immediately; no drain occurs.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps; tick_c=1 when the count equals TICK_DIV-1.
  - Held at 0 in IDLE and DRAIN, so the first tick comes TICK_DIV cycles after leaving IDLE.
- Outputs:
  - All outputs are registered; each tick's response appears one cycle after the tick edge.
  - rdEN_o and sampleValid_o are one-cycle pulses except in DRAIN.
- IDLE:
  - enable_i=1 moves to PRIME. No pops.
- PRIME (no pops, so the FIFO fills):
  - On a tick with fifoEmpty_i=0, increment primeCnt.
  - On a tick with fifoEmpty_i=1, clear primeCnt to 0.
  - When a tick increments primeCnt to PRIME_TICKS, move to RUN and clear the consecutive-underrun counter.
  - sampleValid_o stays 0.
- RUN, on each tick:
  - fifoEmpty_i=0: rdEN_o=1 and sample_o<=fifoPkt_i, captured at the tick edge. sampleValid_o=1; consecutive-underrun counter cleared.
  - fifoEmpty_i=1: rdEN_o=0 and sample_o holds its previous value. sampleValid_o=1, so the output rate stays constant. underrunCnt_o increments, saturating at all ones. Consecutive-underrun counter increments.
  - If the consecutive-underrun counter reaches UNDERRUN_LIMIT, move to PRIME with primeCnt=0.
  - At most one pop per tick.
- Disable priority:
  - enable_i=0 in PRIME or RUN moves to DRAIN on that edge and overrides a coincident tick: no pop, no sampleValid_o.
- DRAIN:
  - Each cycle, rdEN_o <= !fifoEmpty_i && !rdEN_o. Pops alternate with idle cycles so the empty flag can update.
  - When fifoEmpty_i=1 and rdEN_o=0, move to IDLE.
  - enable_i is ignored until IDLE is reached.
- Other rules:
  - sample_o is never cleared except by reset (or by the optional feature below).
  - underrunCnt_o clears only on reset.

Optional Feature:
- Macro: CDC_SCHED_UNDERRUN_MUTE_EN.
- Defined: on an underrun tick in RUN, sample_o is set to 0 (mute) instead of holding the previous sample; counting and strobes are unchanged.
- Undefined: the last sample is repeated on underrun.

Test Plan:
- Reset then enable, FIFO holding 0x1234, 0x5678, 0xABCD:
  - PRIME consumes 2 ticks, then RUN.
  - On the next ticks, rdEN_o pulses and sample_o=0x1234, then 0x5678, each with sampleValid_o one cycle after the tick.
- In RUN, FIFO empties after sample 0x0042:
  - Each tick gives sampleValid_o=1, rdEN_o=0, sample_o=0x0042, and underrunCnt_o increments.
  - After 4 consecutive underruns, state_o=01.
  - With the macro defined, sample_o=0x0000 instead.
- Force 260 underruns with CNT_WIDTH=8 -> underrunCnt_o saturates at 0xFF.
- Drop enable_i in the same cycle as a tick with 3 words in the FIFO:
  - No sampleValid_o.
  - DRAIN issues 3 rdEN_o pulses on alternating cycles, then state_o=00.
- In PRIME, alternate empty and non-empty on successive ticks -> primeCnt keeps clearing; the block never enters RUN.
- Assert rst_i mid-RUN -> next cycle all outputs are 0 and state_o=00; the tick counter restarts from 0.
